// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and opcode decoding for the MDIO management master.
`default_nettype none

package mdio_pkg;

  localparam logic [1:0] ST_C22       = 2'b01;
  localparam logic [1:0] ST_C45       = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_C22_READ  = 2'b10;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;
  localparam logic [1:0] OP_C45_READ  = 2'b11;

  localparam logic [6:0] HDR_BITS  = 7'd14;
  localparam logic [6:0] TA_BITS   = 7'd2;
  localparam logic [6:0] DATA_BITS = 7'd16;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, DONE} state_t;

  function automatic logic is_read(input logic mode45, input logic [1:0] op);
    return mode45 ? (op == OP_C45_READ || op == OP_C45_RDINC) : (op == OP_C22_READ);
  endfunction

  // Clause 45 accepts every opcode; Clause 22 only defines write and read.
  function automatic logic is_legal(input logic mode45, input logic [1:0] op);
    return mode45 || op == OP_WRITE || op == OP_C22_READ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdio_clk_gen.sv
// MDC divider: each bit lasts 2*CLK_DIV cycles, low half first, with end-of-bit strobes.
`default_nettype none

module mdio_clk_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic mdc_o,
  output logic fall_stb_o,
  output logic sample_stb_o
);

  localparam logic [8:0] C_HALF = 9'(CLK_DIV);
  localparam logic [8:0] C_LAST = 9'(2 * CLK_DIV - 1);

  logic [8:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == C_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 9'd1;
    end
  end

  // Both strobes fire on the final cycle of a bit: MDIN is captured there and
  // the next bit is launched on the edge that closes it (MDC falls).
  assign mdc_o        = (cnt_q >= C_HALF);
  assign fall_stb_o   = (cnt_q == C_LAST);
  assign sample_stb_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mdio_mgmt_master.sv
// Clause 22 / Clause 45 MDIO management master: serialises host requests onto MDC/MDIO.
`default_nettype none

module mdio_mgmt_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32,
  parameter int C45_ENABLE   = 1
) (
  input  logic        HOSTCLK,
  input  logic        RESET,
  input  logic        HOSTREQ,
  input  logic [1:0]  HOSTOPCODE,
  input  logic        MODE45,
  input  logic        PRE_SUPPRESS,
  input  logic [4:0]  PHYAD,
  input  logic [4:0]  REGAD,
  input  logic [15:0] HOSTWRDATA,
  output logic        HOSTMIIMRDY,
  output logic [15:0] HOSTRDDATA,
  output logic        HOSTRDVLD,
  output logic        HOSTERR,
  output logic        EMACPHYMCLKOUT,
  output logic        EMACPHYMDOUT,
  output logic        EMACPHYMDTRI,
  input  logic        PHYEMACMDIN
);

  state_t      state_q, state_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [14:0] rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        ta_err_q, ta_err_d;
  logic        mdout_q, mdout_d;
  logic        mdtri_q, mdtri_d;
  logic [15:0] rddata_q, rddata_d;
  logic        rdvld_q, rdvld_d;
  logic        err_q, err_d;

  logic        w_mode45, w_use_pre, w_fall_stb, w_sample_stb, w_clk_rst;
  logic [31:0] w_frame;
  logic [15:0] w_rx_shift;

  assign w_mode45   = (C45_ENABLE != 0) && MODE45;
  assign w_use_pre  = !PRE_SUPPRESS && (PREAMBLE_LEN > 0);
  assign w_frame    = {(w_mode45 ? ST_C45 : ST_C22), HOSTOPCODE, PHYAD, REGAD, 2'b10, HOSTWRDATA};
  assign w_rx_shift = {rx_q, PHYEMACMDIN};
  assign w_clk_rst  = RESET || state_q == IDLE || state_q == DONE;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i        (HOSTCLK),
    .rst_i        (w_clk_rst),
    .mdc_o        (EMACPHYMCLKOUT),
    .fall_stb_o   (w_fall_stb),
    .sample_stb_o (w_sample_stb)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    ta_err_d  = ta_err_q;
    mdout_d   = mdout_q;
    mdtri_d   = mdtri_q;
    rddata_d  = rddata_q;
    rdvld_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (HOSTREQ) begin
          if (!is_legal(w_mode45, HOSTOPCODE)) begin
            err_d = 1'b1;
          end else begin
            rd_d     = is_read(w_mode45, HOSTOPCODE);
            ta_err_d = 1'b0;
            mdtri_d  = 1'b0;
            // sh_q always holds the bits not yet launched; MDOUT shows the current one.
            if (w_use_pre) begin
              state_d   = PREAMBLE;
              bit_cnt_d = 7'(PREAMBLE_LEN - 1);
              mdout_d   = 1'b1;
              sh_d      = w_frame;
            end else begin
              state_d   = HEADER;
              bit_cnt_d = HDR_BITS - 7'd1;
              mdout_d   = w_frame[31];
              sh_d      = {w_frame[30:0], 1'b0};
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (w_sample_stb) begin
          if (state_q == TA && bit_cnt_q == 7'd0) ta_err_d = PHYEMACMDIN;
          if (state_q == DATA) rx_d = w_rx_shift[14:0];
        end
        if (w_fall_stb) begin
          if (bit_cnt_q != 7'd0) begin
            bit_cnt_d = bit_cnt_q - 7'd1;
            if (state_q == PREAMBLE) begin
              mdout_d = 1'b1;
            end else begin
              mdout_d = sh_q[31];
              sh_d    = {sh_q[30:0], 1'b0};
            end
          end else begin
            case (state_q)
              PREAMBLE: begin state_d = HEADER; bit_cnt_d = HDR_BITS - 7'd1;  end
              HEADER:   begin state_d = TA;     bit_cnt_d = TA_BITS - 7'd1;   end
              TA:       begin state_d = DATA;   bit_cnt_d = DATA_BITS - 7'd1; end
              default:  begin state_d = DONE;   bit_cnt_d = 7'd0;             end
            endcase
            if (state_q == HEADER && rd_q) mdtri_d = 1'b1;
            if (state_q == DATA) begin
              mdout_d = 1'b1;
              mdtri_d = 1'b1;
              if (rd_q) begin
                rddata_d = w_rx_shift;
                rdvld_d  = 1'b1;
                err_d    = ta_err_q;
              end
            end else begin
              mdout_d = sh_q[31];
              sh_d    = {sh_q[30:0], 1'b0};
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HOSTCLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      rd_q      <= 1'b0;
      ta_err_q  <= 1'b0;
      mdout_q   <= 1'b1;
      mdtri_q   <= 1'b1;
      rddata_q  <= '0;
      rdvld_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      ta_err_q  <= ta_err_d;
      mdout_q   <= mdout_d;
      mdtri_q   <= mdtri_d;
      rddata_q  <= rddata_d;
      rdvld_q   <= rdvld_d;
      err_q     <= err_d;
    end
  end

  assign HOSTMIIMRDY  = (state_q == IDLE);
  assign HOSTRDDATA   = rddata_q;
  assign HOSTRDVLD    = rdvld_q;
  assign HOSTERR      = err_q;
  assign EMACPHYMDOUT = mdout_q;
  assign EMACPHYMDTRI = mdtri_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_mgmt_master.sv
// Scoreboard bench for mdio_mgmt_master: directed frames, PHY model and response monitor.
`default_nettype none

module tb_mdio_mgmt_master;

  localparam int CD = 2;

  logic        HOSTCLK = 1'b0;
  logic        RESET;
  logic        HOSTREQ;
  logic [1:0]  HOSTOPCODE;
  logic        MODE45;
  logic        PRE_SUPPRESS;
  logic [4:0]  PHYAD;
  logic [4:0]  REGAD;
  logic [15:0] HOSTWRDATA;
  logic        HOSTMIIMRDY;
  logic [15:0] HOSTRDDATA;
  logic        HOSTRDVLD;
  logic        HOSTERR;
  logic        EMACPHYMCLKOUT;
  logic        EMACPHYMDOUT;
  logic        EMACPHYMDTRI;
  logic        PHYEMACMDIN;

  mdio_mgmt_master #(.CLK_DIV(CD), .PREAMBLE_LEN(32), .C45_ENABLE(1)) dut (
    .HOSTCLK        (HOSTCLK),
    .RESET          (RESET),
    .HOSTREQ        (HOSTREQ),
    .HOSTOPCODE     (HOSTOPCODE),
    .MODE45         (MODE45),
    .PRE_SUPPRESS   (PRE_SUPPRESS),
    .PHYAD          (PHYAD),
    .REGAD          (REGAD),
    .HOSTWRDATA     (HOSTWRDATA),
    .HOSTMIIMRDY    (HOSTMIIMRDY),
    .HOSTRDDATA     (HOSTRDDATA),
    .HOSTRDVLD      (HOSTRDVLD),
    .HOSTERR        (HOSTERR),
    .EMACPHYMCLKOUT (EMACPHYMCLKOUT),
    .EMACPHYMDOUT   (EMACPHYMDOUT),
    .EMACPHYMDTRI   (EMACPHYMDTRI),
    .PHYEMACMDIN    (PHYEMACMDIN)
  );

  always #5 HOSTCLK = ~HOSTCLK;

  typedef struct packed {
    logic [15:0] data;
    logic        vld;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every RDVLD/ERR pulse must match the oldest queued expectation.
  always @(negedge HOSTCLK) begin
    if (RESET === 1'b0 && (HOSTRDVLD === 1'b1 || HOSTERR === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got rdvld=%0b err=%0b, expected no response", HOSTRDVLD, HOSTERR);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rdvld", {31'd0, HOSTRDVLD}, {31'd0, mon_e.vld});
        chk("resp_err", {31'd0, HOSTERR}, {31'd0, mon_e.err});
        if (mon_e.vld) chk("resp_data", {16'd0, HOSTRDDATA}, {16'd0, mon_e.data});
      end
    end
  end

  task automatic drive_req(input logic m45, input logic [1:0] op, input logic pre_sup,
                           input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] wd);
    MODE45       = m45;
    HOSTOPCODE   = op;
    PRE_SUPPRESS = pre_sup;
    PHYAD        = phy;
    REGAD        = regad;
    HOSTWRDATA   = wd;
    HOSTREQ      = 1'b1;
    @(negedge HOSTCLK);
    HOSTREQ      = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic m45, input logic [1:0] op,
                           input logic pre_sup, input logic [4:0] phy, input logic [4:0] regad,
                           input logic [15:0] wd, input logic is_rd, input logic [13:0] exp_hdr,
                           input logic [17:0] exp_tail, input logic phy_ok,
                           input logic [15:0] phy_data, input logic poke);
    int          n;
    int          pl;
    logic [63:0] mdo_bits;
    logic [63:0] tri_bits;
    logic        mdc_ok;
    logic [15:0] dsh;
    pl       = pre_sup ? 0 : 32;
    n        = pl + 32;
    mdo_bits = '0;
    tri_bits = '0;
    mdc_ok   = 1'b1;
    dsh      = phy_data;
    if (is_rd) exp_q.push_back('{data: (phy_ok ? phy_data : 16'hFFFF), vld: 1'b1, err: !phy_ok});
    drive_req(m45, op, pre_sup, phy, regad, wd);
    chk({tag, "_rdy_drop"}, {31'd0, HOSTMIIMRDY}, 32'd0);
    for (int b = 0; b < n; b++) begin
      int j;
      j        = b - pl;
      mdo_bits = {mdo_bits[62:0], EMACPHYMDOUT};
      tri_bits = {tri_bits[62:0], EMACPHYMDTRI};
      if (is_rd && phy_ok && j == 15) begin
        PHYEMACMDIN = 1'b0;
      end else if (is_rd && phy_ok && j >= 16) begin
        PHYEMACMDIN = dsh[15];
        dsh         = {dsh[14:0], 1'b0};
      end else begin
        PHYEMACMDIN = 1'b1;
      end
      for (int k = 0; k < 2 * CD; k++) begin
        if (k < CD && EMACPHYMCLKOUT !== 1'b0) mdc_ok = 1'b0;
        if (k >= CD && EMACPHYMCLKOUT !== 1'b1) mdc_ok = 1'b0;
        if (poke && b == 3 && k == 1) begin HOSTREQ = 1'b1; HOSTOPCODE = 2'b11; end
        if (poke && b == 3 && k == 2) begin HOSTREQ = 1'b0; HOSTOPCODE = op; end
        @(negedge HOSTCLK);
      end
    end
    PHYEMACMDIN = 1'b1;
    chk({tag, "_hdr"}, {18'd0, mdo_bits[31:18]}, {18'd0, exp_hdr});
    if (pl != 0) chk({tag, "_preamble"}, mdo_bits[63:32], 32'hFFFF_FFFF);
    if (pl != 0) chk({tag, "_pre_tri"}, tri_bits[63:32], 32'h0);
    if (!is_rd) chk({tag, "_tail"}, {14'd0, mdo_bits[17:0]}, {14'd0, exp_tail});
    chk({tag, "_tri"}, tri_bits[31:0], is_rd ? 32'h0003_FFFF : 32'h0);
    chk({tag, "_mdc"}, {31'd0, mdc_ok}, 32'd1);
    chk({tag, "_done_pins"}, {30'd0, EMACPHYMDTRI, EMACPHYMDOUT}, 32'd3);
    chk({tag, "_done_rdy"}, {31'd0, HOSTMIIMRDY}, 32'd0);
    chk({tag, "_done_rdvld"}, {31'd0, HOSTRDVLD}, {31'd0, is_rd});
    @(negedge HOSTCLK);
    chk({tag, "_rdy_back"}, {31'd0, HOSTMIIMRDY}, 32'd1);
    @(negedge HOSTCLK);
    chk({tag, "_rdy_stays"}, {31'd0, HOSTMIIMRDY}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic bad_mdc, bad_rdy, bad_vld;
    RESET = 1'b1; HOSTREQ = 1'b0; HOSTOPCODE = 2'b00; MODE45 = 1'b0; PRE_SUPPRESS = 1'b0;
    PHYAD = '0; REGAD = '0; HOSTWRDATA = '0; PHYEMACMDIN = 1'b1;
    repeat (3) @(negedge HOSTCLK);
    chk("reset_rdy", {31'd0, HOSTMIIMRDY}, 32'd1);
    chk("reset_rddata", {16'd0, HOSTRDDATA}, 32'd0);
    chk("reset_pulses", {30'd0, HOSTRDVLD, HOSTERR}, 32'd0);
    chk("reset_pins", {29'd0, EMACPHYMCLKOUT, EMACPHYMDOUT, EMACPHYMDTRI}, 32'b011);
    RESET = 1'b0;
    @(negedge HOSTCLK);

    // C22 write 0x1140 to PHY 1 reg 0 with preamble
    run_frame("c22wr", 1'b0, 2'b01, 1'b0, 5'h01, 5'h00, 16'h1140, 1'b0,
              14'h1420, 18'h21140, 1'b1, 16'h0000, 1'b0);
    // C22 read, preamble suppressed, PHY answers 0x796D
    run_frame("c22rd", 1'b0, 2'b10, 1'b1, 5'h01, 5'h01, 16'h0000, 1'b1,
              14'h1821, 18'h0, 1'b1, 16'h796D, 1'b0);
    // C22 read with no PHY: MDIN floats high
    run_frame("nophy", 1'b0, 2'b10, 1'b1, 5'h03, 5'h02, 16'h0000, 1'b1,
              14'h1862, 18'h0, 1'b0, 16'h0000, 1'b0);

    // Illegal C22 opcode 11
    exp_q.push_back('{data: 16'h0, vld: 1'b0, err: 1'b1});
    drive_req(1'b0, 2'b11, 1'b0, 5'h01, 5'h00, 16'h0);
    chk("illegal_err", {31'd0, HOSTERR}, 32'd1);
    bad_mdc = 1'b0; bad_rdy = 1'b0;
    repeat (20) begin
      if (EMACPHYMCLKOUT !== 1'b0) bad_mdc = 1'b1;
      if (HOSTMIIMRDY !== 1'b1) bad_rdy = 1'b1;
      @(negedge HOSTCLK);
    end
    chk("illegal_no_mdc", {31'd0, bad_mdc}, 32'd0);
    chk("illegal_rdy_held", {31'd0, bad_rdy}, 32'd0);

    // C45 address frame with an ignored request while busy, then the C45 read
    run_frame("c45addr", 1'b1, 2'b00, 1'b0, 5'h02, 5'h01, 16'h0007, 1'b0,
              14'h0041, 18'h20007, 1'b1, 16'h0000, 1'b1);
    chk("rddata_hold", {16'd0, HOSTRDDATA}, 32'h0000_FFFF);
    run_frame("c45rd", 1'b1, 2'b11, 1'b0, 5'h02, 5'h01, 16'h0000, 1'b1,
              14'h0C41, 18'h0, 1'b1, 16'hBEEF, 1'b0);

    // Reset during the DATA phase of a read (bit 20 of a suppressed frame)
    drive_req(1'b0, 2'b10, 1'b1, 5'h01, 5'h01, 16'h0);
    repeat (20 * 2 * CD) @(negedge HOSTCLK);
    RESET = 1'b1;
    @(negedge HOSTCLK);
    RESET = 1'b0;
    chk("abort_pins", {30'd0, EMACPHYMCLKOUT, EMACPHYMDTRI}, 32'b01);
    chk("abort_rdy", {31'd0, HOSTMIIMRDY}, 32'd1);
    bad_vld = 1'b0;
    repeat (150) begin
      if (HOSTRDVLD !== 1'b0 || HOSTERR !== 1'b0) bad_vld = 1'b1;
      @(negedge HOSTCLK);
    end
    chk("abort_no_resp", {31'd0, bad_vld}, 32'd0);
    run_frame("postrst", 1'b0, 2'b01, 1'b1, 5'h1F, 5'h1F, 16'hA5A5, 1'b0,
              14'h17FF, 18'h2A5A5, 1'b1, 16'h0000, 1'b0);

    repeat (4) @(negedge HOSTCLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
